// File: rtl/cb_rr_write_arbiter_pkg.sv
// Shared sizing helpers and defaults for the circular-buffer write-side blocks.
package cb_pkg;

    localparam int unsigned CB_DEFAULT_DEPTH = 8;

    function automatic int unsigned cb_cnt_w(input int unsigned depth);
        return unsigned'($clog2(depth + 1));
    endfunction

    function automatic int unsigned cb_id_w(input int unsigned n);
        return (n <= 2) ? 1 : unsigned'($clog2(n));
    endfunction

endpackage

// File: rtl/cb_rr_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
    import cb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = cb_id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    // Wider sum so the modulo wrap also works when N is not a power of two.
    always_comb begin
        any        = 1'b0;
        gnt_idx    = '0;
        gnt_onehot = '0;
        sum        = '0;
        pos        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N)) begin
                sum = sum - (IW + 1)'(N);
            end
            pos = sum[IW-1:0];
            if (!any && req[pos]) begin
                any     = 1'b1;
                gnt_idx = pos;
            end
        end
        gnt_onehot[gnt_idx] = any;
    end

endmodule

// File: rtl/cb_rr_write_arbiter.sv
// Round-robin arbiter sharing one circular_buffer write port among NUM_REQ producers,
// with a conservative credit counter that keeps producers from overfilling the buffer.
module cb_rr_write_arbiter
    import cb_pkg::*;
#(
    parameter  type         T       = logic [31:0],
    parameter  int unsigned DEPTH   = CB_DEFAULT_DEPTH,
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = cb_id_w(NUM_REQ),
    localparam int unsigned CNT_W   = cb_cnt_w(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  T                   req_data [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    input  logic               pause,
    output logic               cb_write_en,
    output T                   cb_write_data,
    output logic [ID_W-1:0]    grant_id,
    input  logic               cb_read_en,
    input  logic               cb_empty,
    input  logic               cb_full,
    output logic [CNT_W-1:0]   occupancy
);

    logic [ID_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]    gnt_idx;
    logic               any;
    logic               avail;
    logic               push;
    logic               pop;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // A pop in the full cycle does not free a credit until the next cycle.
    always_comb begin
        avail     = (occupancy < CNT_W'(DEPTH)) && !pause && rst_n;
        req_ready = avail ? gnt_onehot : '0;
        push      = avail && any;
        pop       = cb_read_en && !cb_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cb_write_en   <= 1'b0;
            cb_write_data <= '0;
            grant_id      <= '0;
            rr_ptr        <= '0;
            occupancy     <= '0;
        end else begin
            cb_write_en <= push;
            if (push) begin
                cb_write_data <= req_data[gnt_idx];
                grant_id      <= gnt_idx;
                rr_ptr        <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
        occupancy <= CNT_W'(DEPTH))
        else $error("occupancy above DEPTH");

    a_write_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(cb_write_en && cb_full))
        else $error("write issued into full buffer");

    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $countones(req_ready) <= 1)
        else $error("more than one req_ready set");

endmodule
